// File: rtl/tone_meter.sv
// Tone meter: measures the full period of an incoming square wave in prescaled
// ticks of CLK_DIV clocks, and reports lock and loss-of-signal status.
module tone_meter #(
    parameter int unsigned CLK_DIV       = 12,
    parameter int unsigned TIMEOUT_TICKS = 100000,
    parameter int unsigned TOLERANCE     = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        tone_in,
    output logic [31:0] period,
    output logic        period_valid,
    output logic        locked,
    output logic        no_signal
);

    localparam int unsigned       PRE_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_DIV - 1);
    localparam logic [31:0]       TIMEOUT_T = 32'(TIMEOUT_TICKS);
    localparam logic [31:0]       TOL       = 32'(TOLERANCE);

    typedef enum logic {
        S_IDLE,
        S_MEASURE
    } state_e;

    logic             sync1_q, sync2_q, prev_q, rise_q;
    state_e           state_q, state_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [31:0]      tick_cnt_q, tick_cnt_d;
    logic [31:0]      period_q, period_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             no_sig_q, no_sig_d;
    logic             have_prev_q, have_prev_d;

    logic             pre_wrap;
    logic [31:0]      tick_inc;
    logic [31:0]      diff;
    logic             timeout_hit;

    // The edge strobe is registered so a measurement is reported exactly three
    // clocks after tone_in is first sampled high.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= tone_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rise_q  <= sync2_q & ~prev_q;
        end
    end

    // tick_inc is the tick count including the current cycle, i.e. floor(N/CLK_DIV)
    // when a rise lands on this edge.
    always_comb begin
        pre_wrap = (pre_cnt_q == PRE_LAST);
        tick_inc = tick_cnt_q;
        if (pre_wrap && (tick_cnt_q < TIMEOUT_T)) begin
            tick_inc = tick_cnt_q + 32'd1;
        end
        timeout_hit = (tick_inc >= TIMEOUT_T);
        diff = (tick_inc >= period_q) ? (tick_inc - period_q) : (period_q - tick_inc);
    end

    // NOTE: every next-state signal takes its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        tick_cnt_d  = tick_cnt_q;
        period_d    = period_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        no_sig_d    = no_sig_q;
        have_prev_d = have_prev_q;

        case (state_q)
            S_IDLE: begin
                pre_cnt_d   = '0;
                tick_cnt_d  = '0;
                have_prev_d = 1'b0;
                if (rise_q) begin
                    state_d = S_MEASURE;
                end
            end

            S_MEASURE: begin
                pre_cnt_d  = pre_wrap ? '0 : pre_cnt_q + 1'b1;
                tick_cnt_d = tick_inc;
                if (rise_q) begin
                    period_d    = tick_inc;
                    valid_d     = 1'b1;
                    no_sig_d    = 1'b0;
                    locked_d    = have_prev_q && (diff <= TOL);
                    have_prev_d = 1'b1;
                    pre_cnt_d   = '0;
                    tick_cnt_d  = '0;
                end else if (timeout_hit) begin
                    no_sig_d    = 1'b1;
                    locked_d    = 1'b0;
                    have_prev_d = 1'b0;
                    pre_cnt_d   = '0;
                    tick_cnt_d  = '0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            pre_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            no_sig_q    <= 1'b1;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            no_sig_q    <= no_sig_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign no_signal    = no_sig_q;

endmodule
